// File: rtl/eth_frame_tx.sv
// Ethernet TX framer: prepends a 14-byte header to a byte payload and emits it as a nibble
// stream to tx_mac, zero-padding short payloads and truncating long ones.
module eth_frame_tx #(
   parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
   parameter logic [15:0] ETHERTYPE   = 16'h88B5,
   parameter int unsigned MIN_PAYLOAD = 46,
   parameter int unsigned MAX_PAYLOAD = 1500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_vld,
   input  logic [7:0]  in_dat,
   input  logic        in_last,
   output logic        in_rdy,
   output logic        tx_vld,
   output logic [3:0]  tx_dat,
   output logic        tx_eof,
   input  logic        tx_ack,
   output logic [15:0] frames_sent,
   output logic [15:0] frames_trunc
);

   typedef enum logic [2:0] {StIdle, StHdr, StPayload, StPad, StDrop} state_e;

   localparam logic [111:0] Hdr     = {DST_MAC, SRC_MAC, ETHERTYPE};
   localparam logic [10:0]  MinCnt  = 11'(MIN_PAYLOAD);
   localparam logic [10:0]  MaxCnt  = 11'(MAX_PAYLOAD);
   localparam logic [10:0]  HdrLast = 11'd13;

   state_e      state_q, state_d;
   logic        phase_q, phase_d;
   logic [10:0] cnt_q, cnt_d;
   logic [15:0] sent_q, sent_d;
   logic [15:0] trunc_q, trunc_d;

   logic [7:0]  hdr_byte;
   logic [10:0] cnt_inc;
   logic        hs;

   assign frames_sent  = sent_q;
   assign frames_trunc = trunc_q;

   // cnt_q doubles as the header byte index while in StHdr
   always_comb begin
      hdr_byte = 8'(Hdr >> (7'd104 - 7'({cnt_q[3:0], 3'b000})));
      cnt_inc  = cnt_q + 11'd1;
      tx_vld   = 1'b0;
      tx_dat   = 4'h0;
      tx_eof   = 1'b0;
      in_rdy   = 1'b0;
      unique case (state_q)
         StHdr: begin
            tx_vld = 1'b1;
            tx_dat = phase_q ? hdr_byte[7:4] : hdr_byte[3:0];
         end
         StPayload: begin
            tx_vld = in_vld;
            tx_dat = phase_q ? in_dat[7:4] : in_dat[3:0];
            in_rdy = tx_ack & phase_q;
            tx_eof = in_vld & phase_q &
                     ((in_last & (cnt_inc >= MinCnt)) | (cnt_inc == MaxCnt));
         end
         StPad: begin
            tx_vld = 1'b1;
            tx_eof = phase_q & (cnt_inc == MinCnt);
         end
         StDrop: in_rdy = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      hs      = tx_vld & tx_ack;
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      sent_d  = sent_q;
      trunc_d = trunc_q;
      if (hs) phase_d = ~phase_q;
      if (hs && tx_eof) sent_d = sent_q + 16'd1;
      unique case (state_q)
         StIdle: begin
            if (in_vld) begin
               state_d = StHdr;
               cnt_d   = '0;
               phase_d = 1'b0;
            end
         end
         StHdr: begin
            if (hs && phase_q) begin
               if (cnt_q == HdrLast) begin
                  state_d = StPayload;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         StPayload: begin
            if (in_vld && in_rdy) begin
               cnt_d = cnt_inc;
               if (tx_eof) begin
                  // eof without in_last can only mean the MAX_PAYLOAD cut-off
                  state_d = in_last ? StIdle : StDrop;
                  if (!in_last) trunc_d = trunc_q + 16'd1;
               end else if (in_last) begin
                  state_d = StPad;
               end
            end
         end
         StPad: begin
            if (hs && phase_q) begin
               cnt_d = cnt_inc;
               if (tx_eof) state_d = StIdle;
            end
         end
         StDrop: begin
            if (in_vld && in_last) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         phase_q <= 1'b0;
         cnt_q   <= '0;
         sent_q  <= '0;
         trunc_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         sent_q  <= sent_d;
         trunc_q <= trunc_d;
      end
   end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: captures every acked nibble and compares against a
// reference frame built from hand-written header bytes and the known payload pattern.
module tb_eth_frame_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_vld = 1'b0;
   logic [7:0]  in_dat = 8'h00;
   logic        in_last = 1'b0;
   logic        in_rdy;
   logic        tx_vld;
   logic [3:0]  tx_dat;
   logic        tx_eof;
   logic        tx_ack = 1'b1;
   logic [15:0] frames_sent;
   logic [15:0] frames_trunc;
   bit          ack_toggle = 1'b0;

   int n_checks = 0;
   int n_pass = 0;

   eth_frame_tx dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_vld       (in_vld),
      .in_dat       (in_dat),
      .in_last      (in_last),
      .in_rdy       (in_rdy),
      .tx_vld       (tx_vld),
      .tx_dat       (tx_dat),
      .tx_eof       (tx_eof),
      .tx_ack       (tx_ack),
      .frames_sent  (frames_sent),
      .frames_trunc (frames_trunc)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_ack = ack_toggle ? ~tx_ack : 1'b1;
      end
   end

   // Monitor: nibble capture, hold-stability and eof-to-next-frame gap
   logic [3:0] nibs[$];
   bit         eofs[$];
   int         stab_err = 0;
   int         last_gap = -1;
   int         gap = 0;
   bit         after_eof = 1'b0;
   bit         prev_hold = 1'b0;
   logic [3:0] prev_dat = 4'h0;
   logic       prev_eof = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold <= 1'b0;
         after_eof <= 1'b0;
         last_gap  <= -1;
      end else begin
         if (prev_hold && (!tx_vld || tx_dat !== prev_dat || tx_eof !== prev_eof))
            stab_err <= stab_err + 1;
         prev_hold <= tx_vld && !tx_ack;
         prev_dat  <= tx_dat;
         prev_eof  <= tx_eof;
         if (tx_vld && tx_ack) begin
            nibs.push_back(tx_dat);
            eofs.push_back(tx_eof);
         end
         if (tx_vld && tx_ack && tx_eof) begin
            after_eof <= 1'b1;
            gap       <= 0;
         end else if (after_eof) begin
            if (tx_vld) begin
               last_gap  <= gap;
               after_eof <= 1'b0;
            end else begin
               gap <= gap + 1;
            end
         end
      end
   end

   logic [7:0] hdr_bytes [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                  8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                                  8'h88, 8'hB5};
   logic [3:0] exp_nib[$];
   bit         exp_eof[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] pay(input int mode, input int i);
      case (mode)
         1: begin
            case (i)
               0: return 8'hA5;
               1: return 8'h5A;
               default: return 8'hC3;
            endcase
         end
         2: return 8'(i * 7 + 3);
         default: return 8'(i);
      endcase
   endfunction

   function automatic int nib_at(input int idx);
      if (idx < nibs.size()) return int'(nibs[idx]);
      return -1;
   endfunction

   function automatic int eof_at(input int idx);
      if (idx < eofs.size()) return int'(eofs[idx]);
      return -1;
   endfunction

   function automatic int eof_count(input int base);
      int c = 0;
      for (int i = base; i < eofs.size(); i++) c += int'(eofs[i]);
      return c;
   endfunction

   // Reference frame appended to exp_nib/exp_eof
   task automatic build_exp(input int n, input int mode);
      int sent = (n > 1500) ? 1500 : n;
      int total = (sent < 46) ? 46 : sent;
      logic [7:0] b;
      for (int i = 0; i < 14; i++) begin
         exp_nib.push_back(hdr_bytes[i][3:0]);
         exp_eof.push_back(1'b0);
         exp_nib.push_back(hdr_bytes[i][7:4]);
         exp_eof.push_back(1'b0);
      end
      for (int i = 0; i < total; i++) begin
         b = (i < sent) ? pay(mode, i) : 8'h00;
         exp_nib.push_back(b[3:0]);
         exp_eof.push_back(1'b0);
         exp_nib.push_back(b[7:4]);
         exp_eof.push_back(i == total - 1);
      end
   endtask

   task automatic cmp_frames(input string tag, input int base);
      int mism = 0;
      for (int i = 0; i < exp_nib.size(); i++) begin
         if (nib_at(base + i) != int'(exp_nib[i]) || eof_at(base + i) != int'(exp_eof[i]))
            mism++;
      end
      check({tag, "_len"}, nibs.size() - base, exp_nib.size());
      check({tag, "_seq"}, mism, 0);
   endtask

   task automatic send_frame(input int n, input int mode, input bit hold, output int slow);
      slow = 0;
      for (int i = 0; i < n; i++) begin
         int waited;
         bit acc;
         waited  = 0;
         acc     = 1'b0;
         in_vld  = 1'b1;
         in_dat  = pay(mode, i);
         in_last = (i == n - 1);
         while (!acc && waited < 400) begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            #1;
            waited++;
         end
         if (!acc) begin
            n_checks++;
            $error("FAIL byte_accept_timeout: byte %0d never accepted, in_rdy 0 expected 1", i);
            in_vld = 1'b0;
            in_last = 1'b0;
            return;
         end
         if (i >= 1500 && waited > 1) slow++;
      end
      if (!hold) begin
         in_vld  = 1'b0;
         in_last = 1'b0;
      end
   endtask

   task automatic wait_frames(input string tag, input int n);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (int'(frames_sent) == n) break;
      end
      check(tag, frames_sent, n);
   endtask

   task automatic do_reset();
      ack_toggle = 1'b0;
      in_vld     = 1'b0;
      in_last    = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int slow;
      int cnt;
      int stab0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {tx_vld, tx_dat, tx_eof, in_rdy, frames_sent, frames_trunc}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // T1: 46-byte payload 0x00..0x2D, exactly minimum length
      base = nibs.size();
      exp_nib.delete();
      exp_eof.delete();
      build_exp(46, 0);
      send_frame(46, 0, 1'b0, slow);
      wait_frames("t1_frames_sent", 1);
      cmp_frames("t1", base);
      cnt = 0;
      for (int i = 0; i < 12; i++) if (nib_at(base + i) == 15) cnt++;
      check("t1_dst_nibbles_f", cnt, 12);
      check("t1_ethertype", {nib_at(base + 24), nib_at(base + 25), nib_at(base + 26),
                             nib_at(base + 27)}, {32'd8, 32'd8, 32'd5, 32'd11});
      check("t1_first_payload", {nib_at(base + 28), nib_at(base + 29)}, 0);
      check("t1_eof_last", eof_at(base + 119), 1);
      check("t1_eof_count", eof_count(base), 1);
      check("t1_trunc", frames_trunc, 0);

      // T2: 3-byte payload gets zero padded
      do_reset();
      base = nibs.size();
      exp_nib.delete();
      exp_eof.delete();
      build_exp(3, 1);
      send_frame(3, 1, 1'b0, slow);
      wait_frames("t2_frames_sent", 1);
      cmp_frames("t2", base);
      check("t2_payload_nibs", {nib_at(base + 28), nib_at(base + 29), nib_at(base + 30),
                                nib_at(base + 31), nib_at(base + 32), nib_at(base + 33)},
            {32'd5, 32'd10, 32'd10, 32'd5, 32'd3, 32'd12});
      cnt = 0;
      for (int i = 34; i < 120; i++) if (nib_at(base + i) == 0) cnt++;
      check("t2_pad_zero_nibs", cnt, 86);
      check("t2_eof_last", eof_at(base + 119), 1);
      check("t2_eof_count", eof_count(base), 1);

      // T3: tx_ack toggling every cycle, 60-byte payload
      do_reset();
      base  = nibs.size();
      stab0 = stab_err;
      exp_nib.delete();
      exp_eof.delete();
      build_exp(60, 2);
      ack_toggle = 1'b1;
      send_frame(60, 2, 1'b0, slow);
      wait_frames("t3_frames_sent", 1);
      ack_toggle = 1'b0;
      cmp_frames("t3", base);
      check("t3_hold_stable", stab_err - stab0, 0);

      // T4: 1600-byte payload truncated at 1500, tail discarded
      do_reset();
      base = nibs.size();
      exp_nib.delete();
      exp_eof.delete();
      build_exp(1600, 0);
      send_frame(1600, 0, 1'b0, slow);
      wait_frames("t4_frames_sent", 1);
      cmp_frames("t4", base);
      check("t4_eof_at_1500", eof_at(base + 3027), 1);
      check("t4_eof_count", eof_count(base), 1);
      check("t4_frames_trunc", frames_trunc, 1);
      check("t4_drop_rdy_slow_bytes", slow, 0);
      @(negedge clk);
      check("t4_back_to_idle", {tx_vld, in_rdy}, 0);

      // T5: asynchronous reset in the middle of the header
      base   = nibs.size();
      in_vld = 1'b1;
      in_dat = 8'h11;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (nibs.size() - base == 10) break;
      end
      check("t5_reached_nibble_10", nibs.size() - base, 10);
      rst_n = 1'b0;
      #1;
      check("t5_reset_outputs", {tx_vld, tx_dat, tx_eof, in_rdy, frames_sent, frames_trunc}, 0);
      in_vld = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      base = nibs.size();
      exp_nib.delete();
      exp_eof.delete();
      build_exp(46, 0);
      send_frame(46, 0, 1'b0, slow);
      wait_frames("t5_frames_sent", 1);
      cmp_frames("t5_after_reset", base);

      // T6: back-to-back frames with in_vld held high
      do_reset();
      base = nibs.size();
      exp_nib.delete();
      exp_eof.delete();
      build_exp(46, 0);
      build_exp(46, 0);
      send_frame(46, 0, 1'b1, slow);
      send_frame(46, 0, 1'b0, slow);
      wait_frames("t6_frames_sent", 2);
      cmp_frames("t6", base);
      check("t6_idle_gap", (last_gap >= 1), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
